// File: rtl/seg_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment driver: prescaled digit scanner,
// per-frame input snapshot, hex glyphs, leading-zero blanking and polarity control.
module seg_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CLK_DIV        = 50000,
    parameter bit          HEX_EN         = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned        IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned        PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_snap_val;
    logic [DIGITS-1:0]   r_snap_dp;
    logic                r_snap_blz;
    logic                r_load_pend;
    logic [6:0]          r_seg;
    logic                r_seg_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_tick;

    logic                w_digit_wrap;
    logic                w_frame_wrap;
    logic                w_load;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic                w_upper_zero;
    logic                w_blank;
    logic [DIGITS-1:0]   w_onehot;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0111111;
            4'h1:    g = 7'b0000110;
            4'h2:    g = 7'b1011011;
            4'h3:    g = 7'b1001111;
            4'h4:    g = 7'b1100110;
            4'h5:    g = 7'b1101101;
            4'h6:    g = 7'b1111101;
            4'h7:    g = 7'b0000111;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1101111;
            4'hA:    g = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'hB:    g = HEX_EN ? 7'b1111100 : 7'b0000000;
            4'hC:    g = HEX_EN ? 7'b0111001 : 7'b0000000;
            4'hD:    g = HEX_EN ? 7'b1011110 : 7'b0000000;
            4'hE:    g = HEX_EN ? 7'b1111001 : 7'b0000000;
            4'hF:    g = HEX_EN ? 7'b1110001 : 7'b0000000;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    assign w_digit_wrap = en && (r_presc == PRE_LAST);
    assign w_frame_wrap = w_digit_wrap && (r_idx == IDX_LAST);
    assign w_load       = en && (r_load_pend || w_frame_wrap);

    // Digit select, one-hot anode, and blanking; scans from the top digit so
    // w_upper_zero holds "this digit and all higher are zero" at each step.
    always_comb begin
        w_nib        = 4'h0;
        w_dp_sel     = 1'b0;
        w_upper_zero = 1'b1;
        w_blank      = 1'b0;
        w_onehot     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_snap_val[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == r_idx) begin
                w_onehot[i] = 1'b1;
                w_nib       = r_snap_val[4*i +: 4];
                w_dp_sel    = r_snap_dp[i];
                w_blank     = r_snap_blz && (i != 0) && w_upper_zero;
            end else begin
                w_onehot[i] = 1'b0;
            end
        end
    end

    // Prescaler and digit index; both hold while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (en) begin
            if (r_presc == PRE_LAST) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end else begin
            r_presc <= r_presc;
            r_idx   <= r_idx;
        end
    end

    // Frame snapshot: reloads at frame end, or on the first enabled cycle after a pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_val  <= '0;
            r_snap_dp   <= '0;
            r_snap_blz  <= 1'b0;
            r_load_pend <= 1'b1;
        end else begin
            if (w_load) begin
                r_snap_val <= value;
                r_snap_dp  <= dp;
                r_snap_blz <= blank_lz;
            end else begin
                r_snap_val <= r_snap_val;
                r_snap_dp  <= r_snap_dp;
                r_snap_blz <= r_snap_blz;
            end
            r_load_pend <= ~en;
        end
    end

    // Registered active-high display outputs; blank whenever scanning is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= '0;
            r_seg        <= 7'b0000000;
            r_seg_dp     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (en) begin
            r_an         <= w_onehot;
            r_seg        <= w_blank ? 7'b0000000 : f_glyph(w_nib);
            r_seg_dp     <= w_dp_sel;
            r_frame_tick <= w_frame_wrap;
        end else begin
            r_an         <= '0;
            r_seg        <= 7'b0000000;
            r_seg_dp     <= 1'b0;
            r_frame_tick <= 1'b0;
        end
    end

    assign seg        = r_seg ^ {7{SEG_ACTIVE_LOW}};
    assign seg_dp     = r_seg_dp ^ SEG_ACTIVE_LOW;
    assign an         = r_an ^ {DIGITS{AN_ACTIVE_LOW}};
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three parameter variants share one stimulus and
// are checked every cycle against a frame-position model plus literal glyph checks.
module tb_seg_scan_driver;

    localparam int D     = 4;
    localparam int CD    = 4;
    localparam int TOTAL = D * CD;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b, an_c;
    logic       ft_a, ft_b, ft_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(D), .CLK_DIV(CD), .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
        .seg(seg_a), .seg_dp(dp_a), .an(an_a), .frame_tick(ft_a));

    seg_scan_driver #(.DIGITS(D), .CLK_DIV(CD), .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_nohex (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
        .seg(seg_b), .seg_dp(dp_b), .an(an_b), .frame_tick(ft_b));

    seg_scan_driver #(.DIGITS(D), .CLK_DIV(CD), .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_inv (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
        .seg(seg_c), .seg_dp(dp_c), .an(an_c), .frame_tick(ft_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a single position-in-frame counter advanced on enabled cycles.
    int          m_pos;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_blz;
    logic        m_pend;
    logic        e_act, e_lit, e_dp, e_ft;
    logic [3:0]  e_an, e_nib;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  <= 0;
            m_val  <= 16'h0;
            m_dp   <= 4'h0;
            m_blz  <= 1'b0;
            m_pend <= 1'b1;
            e_act  <= 1'b0;
            e_lit  <= 1'b0;
            e_dp   <= 1'b0;
            e_ft   <= 1'b0;
            e_an   <= 4'h0;
            e_nib  <= 4'h0;
        end else if (en) begin
            e_act <= 1'b1;
            e_an  <= 4'b0001 << (m_pos / CD);
            e_nib <= m_val[4*(m_pos/CD) +: 4];
            e_lit <= ((m_pos / CD) == 0) || !m_blz || ((m_val >> (4 * (m_pos / CD))) != 16'h0);
            e_dp  <= m_dp[m_pos/CD];
            e_ft  <= (m_pos == TOTAL - 1);
            if (m_pos == TOTAL - 1 || m_pend) begin
                m_val <= value;
                m_dp  <= dp;
                m_blz <= blank_lz;
            end
            m_pend <= 1'b0;
            m_pos  <= (m_pos + 1) % TOTAL;
        end else begin
            e_act  <= 1'b0;
            e_ft   <= 1'b0;
            m_pend <= 1'b1;
        end
    end

    wire [6:0] x_seg     = (e_act && e_lit) ? GLYPH[e_nib] : 7'h00;
    wire [6:0] x_seg_nh  = (e_act && e_lit && e_nib < 4'd10) ? GLYPH[e_nib] : 7'h00;
    wire [3:0] x_an      = e_act ? e_an : 4'h0;
    wire       x_dp      = e_act & e_dp;
    wire [6:0] x_seg_inv = ~x_seg;
    wire [3:0] x_an_inv  = ~x_an;
    wire       x_dp_inv  = ~x_dp;

    always @(negedge clk) begin
        chk("an",         an_a, x_an);
        chk("seg",        seg_a, x_seg);
        chk("seg_dp",     dp_a, x_dp);
        chk("frame_tick", ft_a, e_ft);
        chk("nohex_seg",  seg_b, x_seg_nh);
        chk("nohex_an",   an_b, x_an);
        chk("nohex_ft",   ft_b, e_ft);
        chk("inv_seg",    seg_c, x_seg_inv);
        chk("inv_an",     an_c, x_an_inv);
        chk("inv_dp",     dp_c, x_dp_inv);
        chk("inv_ft",     ft_c, e_ft);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; value = 16'h0; dp = 4'h0; blank_lz = 1'b0;
        #1;
        chk("L_rst_an",      an_a, 4'h0);
        chk("L_rst_seg",     seg_a, 7'h00);
        chk("L_rst_inv_seg", seg_c, 7'h7f);
        chk("L_rst_inv_an",  an_c, 4'hf);
        step(2); rst_n = 1'b1;
        step(1); value = 16'h1234; dp = 4'b0100; en = 1'b1;

        step(2);  chk("L_1234_an0", an_a, 4'b0001); chk("L_1234_d0", seg_a, 7'b1100110); chk("L_1234_dp0", dp_a, 1'b0);
        step(4);  chk("L_1234_an1", an_a, 4'b0010); chk("L_1234_d1", seg_a, 7'b1001111);
        step(4);  chk("L_1234_an2", an_a, 4'b0100); chk("L_1234_d2", seg_a, 7'b1011011); chk("L_1234_dp2", dp_a, 1'b1);
        step(4);  chk("L_1234_an3", an_a, 4'b1000); chk("L_1234_d3", seg_a, 7'b0000110); chk("L_1234_dp3", dp_a, 1'b0);
        step(2);  chk("L_ft_hi", ft_a, 1'b1);
        step(1);  chk("L_ft_lo", ft_a, 1'b0);
        value = 16'hABCD; dp = 4'h0;
        step(16); chk("L_hex_d0", seg_a, 7'b1011110); chk("L_nohex_d0", seg_b, 7'b0000000);
        step(4);  chk("L_hex_d1", seg_a, 7'b0111001); chk("L_nohex_d1", seg_b, 7'b0000000);
        value = 16'h0050; blank_lz = 1'b1;
        step(12); chk("L_lz_d0", seg_a, 7'b0111111);
        step(4);  chk("L_lz_d1", seg_a, 7'b1101101);
        step(4);  chk("L_lz_an2", an_a, 4'b0100); chk("L_lz_d2", seg_a, 7'b0000000);
        step(4);  chk("L_lz_an3", an_a, 4'b1000); chk("L_lz_d3", seg_a, 7'b0000000);
        value = 16'h0000;
        step(4);  chk("L_zero_d0", seg_a, 7'b0111111);
        step(4);  chk("L_zero_an1", an_a, 4'b0010); chk("L_zero_d1", seg_a, 7'b0000000);
        value = 16'h1234; blank_lz = 1'b0;
        step(17); value = 16'h5678;
        step(4);  chk("L_tear_d2", seg_a, 7'b1011011);
        step(4);  chk("L_tear_d3", seg_a, 7'b0000110);
        step(3);  chk("L_next_d0", seg_a, 7'b1111111);
        step(8);  chk("L_pre_gap", seg_a, 7'b1111101);
        en = 1'b0; value = 16'h4321;
        step(1);  chk("L_gap_an", an_a, 4'h0); chk("L_gap_seg", seg_a, 7'h00);
                  chk("L_gap_inv_seg", seg_c, 7'h7f); chk("L_gap_inv_an", an_c, 4'hf);
        step(9);  chk("L_gap_end_an", an_a, 4'h0);
        en = 1'b1;
        step(1);  chk("L_res_an", an_a, 4'b0100); chk("L_res_old", seg_a, 7'b1111101);
        step(1);  chk("L_res_new", seg_a, 7'b1001111);
        step(2);  chk("L_res_an3", an_a, 4'b1000); chk("L_res_d3", seg_a, 7'b1100110);

        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk("L_arst_an", an_a, 4'h0); chk("L_arst_seg", seg_a, 7'h00); chk("L_arst_ft", ft_a, 1'b0);
        chk("L_arst_inv_seg", seg_c, 7'h7f); chk("L_arst_inv_an", an_c, 4'hf);
        step(2); rst_n = 1'b1;
        step(2);  chk("L_rel_an", an_a, 4'b0001); chk("L_rel_d0", seg_a, 7'b0000110);

        value = 16'h0000; dp = 4'b1010; blank_lz = 1'b1;
        step(20);
        en = 1'b0;
        step(1);
        en = 1'b1; value = 16'hF00E; blank_lz = 1'b0;
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
